// File: rtl/multdiv_param_if.sv
// Start/operand/result bundle for the iterative multiply/divide unit.
// master = requester side, slave = the arithmetic unit.
interface multdiv_param_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             ctrl_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_result_hi;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
        input  data_result, data_result_hi, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
        output data_result, data_result_hi, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_param.sv
// Iterative multiplier/divider: WIDTH-cycle shift-add multiply or restoring divide
// on operand magnitudes, followed by one sign-fix cycle and a one-cycle ready pulse.
module multdiv_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             isMult_q, signed_q, negA_q, negB_q;
    logic [WIDTH-1:0] opA_q, bMag_q, acc_q, lo_q;
    logic [WIDTH-1:0] res_q, resHi_q;
    logic             exc_q;

    logic             start;
    logic [WIDTH-1:0] aMagIn, bMagIn;
    logic [WIDTH-1:0] acc_d, lo_d, res_d, resHi_d;
    logic             exc_d;
    logic [WIDTH:0]   addSum, shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [2*WIDTH-1:0] prodMag, prod;
    logic [WIDTH-1:0] quot, rem;

    assign start  = bus.ctrl_MULT | bus.ctrl_DIV;
    assign aMagIn = (bus.ctrl_signed && bus.data_operandA[WIDTH-1]) ? (~bus.data_operandA + 1'b1)
                                                                    : bus.data_operandA;
    assign bMagIn = (bus.ctrl_signed && bus.data_operandB[WIDTH-1]) ? (~bus.data_operandB + 1'b1)
                                                                    : bus.data_operandB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A start pulse wins over every state, which is what makes abort and back-to-back work.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = CALC;
        end else begin
            case (state_q)
                CALC:    if (cnt_q == LAST_ITER) state_d = FIX;
                FIX:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy           = 1'b0;
        bus.data_resultRDY = 1'b0;
        case (state_q)
            CALC, FIX: bus.busy           = 1'b1;
            DONE:      bus.data_resultRDY = 1'b1;
            default:   ;
        endcase
    end

    // One iteration: {acc,lo} is the product shifter for multiply, {remainder,quotient} for divide.
    always_comb begin
        addSum  = {1'b0, acc_q} + {1'b0, bMag_q};
        shifted = {acc_q, lo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, bMag_q});
        diff    = shifted[WIDTH-1:0] - bMag_q;
        if (isMult_q) begin
            acc_d = lo_q[0] ? addSum[WIDTH:1] : {1'b0, acc_q[WIDTH-1:1]};
            lo_d  = {(lo_q[0] ? addSum[0] : acc_q[0]), lo_q[WIDTH-1:1]};
        end else begin
            acc_d = fits ? diff : shifted[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], fits};
        end
    end

    always_comb begin
        prodMag = {acc_q, lo_q};
        prod    = (negA_q ^ negB_q) ? (~prodMag + 1'b1) : prodMag;
        quot    = (negA_q ^ negB_q) ? (~lo_q + 1'b1) : lo_q;
        rem     = negA_q ? (~acc_q + 1'b1) : acc_q;
        if (isMult_q) begin
            res_d   = prod[WIDTH-1:0];
            resHi_d = prod[2*WIDTH-1:WIDTH];
            exc_d   = signed_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                               : (prod[2*WIDTH-1:WIDTH] != '0);
        end else if (bMag_q == '0) begin
            res_d   = '0;
            resHi_d = opA_q;
            exc_d   = 1'b1;
        end else if (negA_q && negB_q && opA_q == MIN_VAL && bMag_q == WIDTH'(1)) begin
            res_d   = MIN_VAL;
            resHi_d = '0;
            exc_d   = 1'b1;
        end else begin
            res_d   = quot;
            resHi_d = rem;
            exc_d   = 1'b0;
        end
    end

    // Visible results load only on the FIX->DONE edge and otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            isMult_q <= 1'b0;
            signed_q <= 1'b0;
            negA_q   <= 1'b0;
            negB_q   <= 1'b0;
            opA_q    <= '0;
            bMag_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            resHi_q  <= '0;
            exc_q    <= 1'b0;
        end else if (start) begin
            cnt_q    <= '0;
            isMult_q <= bus.ctrl_MULT;
            signed_q <= bus.ctrl_signed;
            negA_q   <= bus.ctrl_signed & bus.data_operandA[WIDTH-1];
            negB_q   <= bus.ctrl_signed & bus.data_operandB[WIDTH-1];
            opA_q    <= bus.data_operandA;
            bMag_q   <= bMagIn;
            acc_q    <= '0;
            lo_q     <= aMagIn;
        end else if (state_q == CALC) begin
            cnt_q    <= cnt_q + 1'b1;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
        end else if (state_q == FIX) begin
            res_q    <= res_d;
            resHi_q  <= resHi_d;
            exc_q    <= exc_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_result_hi = resHi_q;
    assign bus.data_exception = exc_q;
endmodule

// File: tb/tb_multdiv_param.sv
// Directed bench for multdiv_param at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_multdiv_param;
    logic clock = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;
    int   edges;
    int   rdySeen;

    always #5 clock = ~clock;

    multdiv_param_if #(.WIDTH(32)) bus32();
    multdiv_param_if #(.WIDTH(8))  bus8();

    multdiv_param #(.WIDTH(32), .CNT_W(6)) dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
    multdiv_param #(.WIDTH(8),  .CNT_W(4)) dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Callers are always at a negedge; the pulse spans exactly one rising edge.
    task automatic startOp32(input logic m, input logic d, input logic s,
                             input logic [31:0] a, input logic [31:0] b);
        bus32.ctrl_MULT = m; bus32.ctrl_DIV = d; bus32.ctrl_signed = s;
        bus32.data_operandA = a; bus32.data_operandB = b;
        @(negedge clock);
        bus32.ctrl_MULT = 1'b0; bus32.ctrl_DIV = 1'b0;
    endtask

    task automatic startOp8(input logic s, input logic [7:0] a, input logic [7:0] b);
        bus8.ctrl_DIV = 1'b1; bus8.ctrl_signed = s;
        bus8.data_operandA = a; bus8.data_operandB = b;
        @(negedge clock);
        bus8.ctrl_DIV = 1'b0;
    endtask

    task automatic waitRdy32(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (bus32.data_resultRDY === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic waitRdy8(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (bus8.data_resultRDY === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus32.ctrl_MULT = 1'b1; bus32.data_operandA = 32'd7; bus32.data_operandB = 32'd3;
        repeat (3) @(negedge clock);
        checkCount++; if (bus32.data_result !== 32'd0) $display("[TB] FAIL rst_lo32: got %h expected 0", bus32.data_result); else passCount++;
        checkCount++; if (bus32.data_result_hi !== 32'd0) $display("[TB] FAIL rst_hi32: got %h expected 0", bus32.data_result_hi); else passCount++;
        checkCount++; if ({bus32.data_exception, bus32.data_resultRDY, bus32.busy} !== 3'b000) $display("[TB] FAIL rst_flags32: got %b expected 000", {bus32.data_exception, bus32.data_resultRDY, bus32.busy}); else passCount++;
        checkCount++; if ({bus8.data_result, bus8.data_result_hi, bus8.data_exception, bus8.data_resultRDY, bus8.busy} !== 19'd0) $display("[TB] FAIL rst_all8: got %h expected 0", {bus8.data_result, bus8.data_result_hi, bus8.data_exception, bus8.data_resultRDY, bus8.busy}); else passCount++;
        bus32.ctrl_MULT = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkCount++; if (bus32.busy !== 1'b0) $display("[TB] FAIL rst_start_ignored: busy got %b expected 0", bus32.busy); else passCount++;
    endtask

    task automatic test_signed_mult();
        startOp32(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFFFFFD);
        checkCount++; if (bus32.busy !== 1'b1) $display("[TB] FAIL smul_busy: got %b expected 1", bus32.busy); else passCount++;
        waitRdy32(edges);
        checkCount++; if (edges !== 33) $display("[TB] FAIL smul_latency: got %0d expected 33", edges); else passCount++;
        checkCount++; if (bus32.data_result !== 32'hFFFFFFEB) $display("[TB] FAIL smul_lo: got %h expected ffffffeb", bus32.data_result); else passCount++;
        checkCount++; if (bus32.data_result_hi !== 32'hFFFFFFFF) $display("[TB] FAIL smul_hi: got %h expected ffffffff", bus32.data_result_hi); else passCount++;
        checkCount++; if ({bus32.data_exception, bus32.busy} !== 2'b00) $display("[TB] FAIL smul_exc_busy: got %b expected 00", {bus32.data_exception, bus32.busy}); else passCount++;
        @(negedge clock);
        checkCount++; if (bus32.data_resultRDY !== 1'b0) $display("[TB] FAIL smul_rdy_pulse: got %b expected 0", bus32.data_resultRDY); else passCount++;
        checkCount++; if (bus32.data_result !== 32'hFFFFFFEB) $display("[TB] FAIL smul_hold: got %h expected ffffffeb", bus32.data_result); else passCount++;
        startOp32(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitRdy32(edges);
        checkCount++; if ({bus32.data_result_hi, bus32.data_result, bus32.data_exception} !== {64'd1, 1'b0}) $display("[TB] FAIL smul_neg1sq: got %h_%h exc %b expected 0_1 exc 0", bus32.data_result_hi, bus32.data_result, bus32.data_exception); else passCount++;
    endtask

    task automatic test_unsigned_mult();
        startOp32(1'b1, 1'b0, 1'b0, 32'h00010000, 32'h00010000);
        waitRdy32(edges);
        checkCount++; if ({bus32.data_result_hi, bus32.data_result} !== 64'h00000001_00000000) $display("[TB] FAIL umul_2p32: got %h_%h expected 1_0", bus32.data_result_hi, bus32.data_result); else passCount++;
        checkCount++; if (bus32.data_exception !== 1'b1) $display("[TB] FAIL umul_2p32_exc: got %b expected 1", bus32.data_exception); else passCount++;
        startOp32(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitRdy32(edges);
        checkCount++; if ({bus32.data_result_hi, bus32.data_result, bus32.data_exception} !== {64'hFFFFFFFE_00000001, 1'b1}) $display("[TB] FAIL umul_max: got %h_%h exc %b expected fffffffe_00000001 exc 1", bus32.data_result_hi, bus32.data_result, bus32.data_exception); else passCount++;
    endtask

    task automatic test_signed_div();
        startOp32(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        waitRdy32(edges);
        checkCount++; if ({bus32.data_result, bus32.data_result_hi, bus32.data_exception} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0}) $display("[TB] FAIL sdiv_m7_2: got q %h r %h exc %b expected q fffffffd r ffffffff exc 0", bus32.data_result, bus32.data_result_hi, bus32.data_exception); else passCount++;
        startOp32(1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE);
        waitRdy32(edges);
        checkCount++; if ({bus32.data_result, bus32.data_result_hi} !== {32'hFFFFFFFD, 32'd1}) $display("[TB] FAIL sdiv_7_m2: got q %h r %h expected q fffffffd r 1", bus32.data_result, bus32.data_result_hi); else passCount++;
        startOp32(1'b0, 1'b1, 1'b1, 32'd5, 32'd0);
        waitRdy32(edges);
        checkCount++; if (edges !== 33) $display("[TB] FAIL div0_latency: got %0d expected 33", edges); else passCount++;
        checkCount++; if ({bus32.data_exception, bus32.data_result, bus32.data_result_hi} !== {1'b1, 32'd0, 32'd5}) $display("[TB] FAIL div0: got exc %b q %h r %h expected exc 1 q 0 r 5", bus32.data_exception, bus32.data_result, bus32.data_result_hi); else passCount++;
    endtask

    task automatic test_width8();
        startOp8(1'b1, 8'h80, 8'hFF);
        waitRdy8(edges);
        checkCount++; if ({bus8.data_exception, bus8.data_result, bus8.data_result_hi} !== {1'b1, 8'h80, 8'h00}) $display("[TB] FAIL w8_minneg: got exc %b q %h r %h expected exc 1 q 80 r 00", bus8.data_exception, bus8.data_result, bus8.data_result_hi); else passCount++;
        startOp8(1'b0, 8'hFF, 8'h10);
        waitRdy8(edges);
        checkCount++; if (edges !== 9) $display("[TB] FAIL w8_latency: got %0d expected 9", edges); else passCount++;
        checkCount++; if ({bus8.data_exception, bus8.data_result, bus8.data_result_hi} !== {1'b0, 8'h0F, 8'h0F}) $display("[TB] FAIL w8_udiv: got exc %b q %h r %h expected exc 0 q 0f r 0f", bus8.data_exception, bus8.data_result, bus8.data_result_hi); else passCount++;
    endtask

    task automatic test_back_to_back();
        startOp32(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        waitRdy32(edges);
        checkCount++; if ({bus32.data_result, bus32.data_result_hi} !== {32'd14, 32'd2}) $display("[TB] FAIL b2b_div: got q %h r %h expected q e r 2", bus32.data_result, bus32.data_result_hi); else passCount++;
        startOp32(1'b1, 1'b1, 1'b0, 32'd6, 32'd7);
        waitRdy32(edges);
        checkCount++; if (edges !== 33) $display("[TB] FAIL b2b_latency: got %0d expected 33", edges); else passCount++;
        checkCount++; if ({bus32.data_result_hi, bus32.data_result} !== 64'd42) $display("[TB] FAIL b2b_mult_priority: got %h_%h expected 0_2a", bus32.data_result_hi, bus32.data_result); else passCount++;
    endtask

    task automatic test_abort();
        startOp32(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        rdySeen = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus32.data_resultRDY === 1'b1) rdySeen++;
        end
        startOp32(1'b0, 1'b1, 1'b0, 32'd10, 32'd3);
        waitRdy32(edges);
        checkCount++; if (edges !== 33 || rdySeen !== 0) $display("[TB] FAIL abort_latency: got %0d edges early rdy %0d expected 33 edges early rdy 0", edges, rdySeen); else passCount++;
        checkCount++; if ({bus32.data_result, bus32.data_result_hi, bus32.data_exception} !== {32'd3, 32'd1, 1'b0}) $display("[TB] FAIL abort_div: got q %h r %h exc %b expected q 3 r 1 exc 0", bus32.data_result, bus32.data_result_hi, bus32.data_exception); else passCount++;
        rdySeen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus32.data_resultRDY === 1'b1) rdySeen++;
        end
        checkCount++; if (rdySeen !== 0) $display("[TB] FAIL abort_single_rdy: got %0d extra pulses expected 0", rdySeen); else passCount++;
    endtask

    task automatic test_abort_reset();
        startOp32(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        repeat (3) @(negedge clock);
        startOp32(1'b0, 1'b1, 1'b0, 32'd10, 32'd3);
        repeat (10) @(negedge clock);
        checkCount++; if ({bus32.data_result, bus32.busy} !== {32'd3, 1'b1}) $display("[TB] FAIL hold_midop: got q %h busy %b expected q 3 busy 1", bus32.data_result, bus32.busy); else passCount++;
        reset = 1'b1;
        #1;
        checkCount++; if ({bus32.data_result, bus32.data_result_hi, bus32.data_exception, bus32.data_resultRDY, bus32.busy} !== 67'd0) $display("[TB] FAIL async_reset: got %h expected 0", {bus32.data_result, bus32.data_result_hi, bus32.data_exception, bus32.data_resultRDY, bus32.busy}); else passCount++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rdySeen = 0;
        repeat (45) begin
            @(negedge clock);
            if (bus32.data_resultRDY === 1'b1) rdySeen++;
        end
        checkCount++; if (rdySeen !== 0) $display("[TB] FAIL reset_no_rdy: got %0d pulses expected 0", rdySeen); else passCount++;
        checkCount++; if ({bus32.data_result, bus32.data_result_hi, bus32.data_exception, bus32.busy} !== 66'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", {bus32.data_result, bus32.data_result_hi, bus32.data_exception, bus32.busy}); else passCount++;
    endtask

    initial begin
        reset = 1'b1;
        bus32.ctrl_MULT = 1'b0; bus32.ctrl_DIV = 1'b0; bus32.ctrl_signed = 1'b0;
        bus32.data_operandA = '0; bus32.data_operandB = '0;
        bus8.ctrl_MULT = 1'b0; bus8.ctrl_DIV = 1'b0; bus8.ctrl_signed = 1'b0;
        bus8.data_operandA = '0; bus8.data_operandB = '0;
        @(negedge clock);
        test_reset();
        test_signed_mult();
        test_unsigned_mult();
        test_signed_div();
        test_width8();
        test_back_to_back();
        test_abort();
        test_abort_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
